// File: rtl/vector_read_sequencer.sv
// Vector register-group read sequencer: one VRF read beat per cycle across an LMUL group.
// Optional busy scoreboard with RAW/WAW issue stall enabled by VECTOR_SCOREBOARD_EN.
module vector_read_sequencer #(
    parameter int VRF_DEPTH         = 32,
    parameter int VRF_ADDRESS_WIDTH = $clog2(VRF_DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [VRF_ADDRESS_WIDTH-1:0] vs1_base_i,
    input  logic [VRF_ADDRESS_WIDTH-1:0] vs2_base_i,
    input  logic [VRF_ADDRESS_WIDTH-1:0] vd_base_i,
    input  logic [2:0]                   vlmul_i,
    input  logic                         uses_vs1_i,
    input  logic                         uses_vs2_i,
    input  logic                         uses_vd_i,
    input  logic                         writes_vd_i,
    output logic                         read_valid_o,
    input  logic                         read_ready_i,
    output logic [VRF_ADDRESS_WIDTH-1:0] vs1_read_address_o,
    output logic [VRF_ADDRESS_WIDTH-1:0] vs2_read_address_o,
    output logic [VRF_ADDRESS_WIDTH-1:0] vd_read_address_o,
    output logic                         first_o,
    output logic                         last_o,
    input  logic                         wb_valid_i,
    input  logic [VRF_ADDRESS_WIDTH-1:0] wb_address_i,
    output logic [VRF_DEPTH-1:0]         busy_o
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t                         r_state, w_state_next;
    logic [2:0]                     r_count, w_count_next;
    logic [2:0]                     r_group_last, w_group_last;
    logic [VRF_ADDRESS_WIDTH-1:0]   r_vs1_base, r_vs2_base, r_vd_base;
    logic                           w_hazard;
    logic                           w_accept;

    // Group size minus one; fractional and reserved encodings read a single register.
    always_comb begin
        case (vlmul_i)
            3'b001:  w_group_last = 3'd1;
            3'b010:  w_group_last = 3'd3;
            3'b011:  w_group_last = 3'd7;
            default: w_group_last = 3'd0;
        endcase
    end

    assign issue_ready_o = (r_state == IDLE) && !w_hazard;
    assign w_accept      = issue_valid_i && issue_ready_o;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SEQ;
                    w_count_next = 3'd0;
                end
            end
            SEQ: begin
                if (read_ready_i) begin
                    if (r_count == r_group_last) w_state_next = IDLE;
                    else                         w_count_next = r_count + 3'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_count      <= 3'd0;
            r_group_last <= 3'd0;
            r_vs1_base   <= '0;
            r_vs2_base   <= '0;
            r_vd_base    <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_accept) begin
                r_group_last <= w_group_last;
                r_vs1_base   <= vs1_base_i;
                r_vs2_base   <= vs2_base_i;
                r_vd_base    <= vd_base_i;
            end
        end
    end

    assign read_valid_o       = (r_state == SEQ);
    assign first_o            = (r_state == SEQ) && (r_count == 3'd0);
    assign last_o             = (r_state == SEQ) && (r_count == r_group_last);
    assign vs1_read_address_o = r_vs1_base + VRF_ADDRESS_WIDTH'(r_count);
    assign vs2_read_address_o = r_vs2_base + VRF_ADDRESS_WIDTH'(r_count);
    assign vd_read_address_o  = r_vd_base  + VRF_ADDRESS_WIDTH'(r_count);

`ifdef VECTOR_SCOREBOARD_EN
    logic [VRF_DEPTH-1:0] r_busy;
    logic [VRF_DEPTH-1:0] w_vs1_mask, w_vs2_mask, w_vd_mask;
    logic [VRF_DEPTH-1:0] w_set, w_clr;

    // Registers covered by a group; the address sum wraps modulo the register count.
    function automatic logic [VRF_DEPTH-1:0] group_mask(
        input logic [VRF_ADDRESS_WIDTH-1:0] base,
        input logic [2:0]                   group_last
    );
        group_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= group_last) group_mask[base + VRF_ADDRESS_WIDTH'(i)] = 1'b1;
        end
    endfunction

    assign w_vs1_mask = group_mask(vs1_base_i, w_group_last);
    assign w_vs2_mask = group_mask(vs2_base_i, w_group_last);
    assign w_vd_mask  = group_mask(vd_base_i,  w_group_last);

    assign w_hazard = |(r_busy & ((uses_vs1_i ? w_vs1_mask : '0)
                                | (uses_vs2_i ? w_vs2_mask : '0)
                                | ((uses_vd_i || writes_vd_i) ? w_vd_mask : '0)));

    assign w_set = (w_accept && writes_vd_i) ? w_vd_mask : '0;

    always_comb begin
        w_clr = '0;
        if (wb_valid_i) w_clr[wb_address_i] = 1'b1;
    end

    // Set is applied after clear so a new writer claiming a retiring register keeps it busy.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_busy <= '0;
        else         r_busy <= (r_busy & ~w_clr) | w_set;
    end

    assign busy_o = r_busy;
`else
    logic w_unused_scoreboard;

    assign w_hazard            = 1'b0;
    assign busy_o              = '0;
    assign w_unused_scoreboard = ^{wb_valid_i, wb_address_i, uses_vs1_i, uses_vs2_i,
                                   uses_vd_i, writes_vd_i};
`endif

endmodule

// File: tb/tb_vector_read_sequencer.sv
// Self-checking bench for vector_read_sequencer: directed scenarios plus random traffic
// compared against a queue-of-beats reference model.
module tb_vector_read_sequencer;

    localparam int D  = 32;
    localparam int AW = 5;
`ifdef VECTOR_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          issue_valid_i, issue_ready_o;
    logic [AW-1:0] vs1_base_i, vs2_base_i, vd_base_i;
    logic [2:0]    vlmul_i;
    logic          uses_vs1_i, uses_vs2_i, uses_vd_i, writes_vd_i;
    logic          read_valid_o, read_ready_i;
    logic [AW-1:0] vs1_read_address_o, vs2_read_address_o, vd_read_address_o;
    logic          first_o, last_o;
    logic          wb_valid_i;
    logic [AW-1:0] wb_address_i;
    logic [D-1:0]  busy_o;

    vector_read_sequencer #(.VRF_DEPTH(D), .VRF_ADDRESS_WIDTH(AW)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .issue_valid_i      (issue_valid_i),
        .issue_ready_o      (issue_ready_o),
        .vs1_base_i         (vs1_base_i),
        .vs2_base_i         (vs2_base_i),
        .vd_base_i          (vd_base_i),
        .vlmul_i            (vlmul_i),
        .uses_vs1_i         (uses_vs1_i),
        .uses_vs2_i         (uses_vs2_i),
        .uses_vd_i          (uses_vd_i),
        .writes_vd_i        (writes_vd_i),
        .read_valid_o       (read_valid_o),
        .read_ready_i       (read_ready_i),
        .vs1_read_address_o (vs1_read_address_o),
        .vs2_read_address_o (vs2_read_address_o),
        .vd_read_address_o  (vd_read_address_o),
        .first_o            (first_o),
        .last_o             (last_o),
        .wb_valid_i         (wb_valid_i),
        .wb_address_i       (wb_address_i),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int a1;
        int a2;
        int ad;
        bit first;
        bit last;
    } beat_t;

    // Reference model: pending beats of the current group and the busy set.
    beat_t        m_q[$];
    bit [D-1:0]   m_busy;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int group_size(input logic [2:0] vlmul);
        case (vlmul)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b011:  return 8;
            default: return 1;
        endcase
    endfunction

    function automatic bit range_busy(input logic [AW-1:0] base, input int g);
        for (int k = 0; k < g; k++) if (m_busy[(int'(base) + k) % D]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ready();
        int g;
        bit hz;
        g  = group_size(vlmul_i);
        hz = SB_EN && ((uses_vs1_i && range_busy(vs1_base_i, g))
                    || (uses_vs2_i && range_busy(vs2_base_i, g))
                    || ((uses_vd_i || writes_vd_i) && range_busy(vd_base_i, g)));
        return (m_q.size() == 0) && !hz;
    endfunction

    task automatic check_outputs();
        check("issue_ready", 32'(issue_ready_o), 32'(exp_ready()));
        check("read_valid", 32'(read_valid_o), 32'(m_q.size() != 0));
        check("busy", busy_o, m_busy);
        if (m_q.size() != 0) begin
            check("vs1_addr", 32'(vs1_read_address_o), m_q[0].a1);
            check("vs2_addr", 32'(vs2_read_address_o), m_q[0].a2);
            check("vd_addr", 32'(vd_read_address_o), m_q[0].ad);
            check("first", 32'(first_o), 32'(m_q[0].first));
            check("last", 32'(last_o), 32'(m_q[0].last));
        end else begin
            check("first_idle", 32'(first_o), 32'd0);
            check("last_idle", 32'(last_o), 32'd0);
        end
    endtask

    task automatic model_update();
        bit acc;
        int g;
        beat_t b;
        acc = issue_valid_i && exp_ready();
        if (m_q.size() != 0 && read_ready_i) void'(m_q.pop_front());
        if (SB_EN && wb_valid_i) m_busy[wb_address_i] = 1'b0;
        if (acc) begin
            g = group_size(vlmul_i);
            for (int k = 0; k < g; k++) begin
                b.a1    = (int'(vs1_base_i) + k) % D;
                b.a2    = (int'(vs2_base_i) + k) % D;
                b.ad    = (int'(vd_base_i) + k) % D;
                b.first = (k == 0);
                b.last  = (k == g - 1);
                m_q.push_back(b);
                if (SB_EN && writes_vd_i) m_busy[b.ad] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        check_outputs();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_issue(input bit v, input int lmul, input int s1, input int s2, input int d,
                             input bit u1, input bit u2, input bit ud, input bit wvd);
        issue_valid_i = v;
        vlmul_i       = 3'(lmul);
        vs1_base_i    = AW'(s1);
        vs2_base_i    = AW'(s2);
        vd_base_i     = AW'(d);
        uses_vs1_i    = u1;
        uses_vs2_i    = u2;
        uses_vd_i     = ud;
        writes_vd_i   = wvd;
    endtask

    initial begin
        rstn_i       = 1'b0;
        read_ready_i = 1'b0;
        wb_valid_i   = 1'b0;
        wb_address_i = '0;
        set_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_q.delete();
        m_busy = '0;
        #12;
        check_outputs();
        check("reset_vd_addr", 32'(vd_read_address_o), 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        // Single-register group, addresses 3/5/7, vd 7 becomes busy.
        read_ready_i = 1'b1;
        set_issue(1, 0, 3, 5, 7, 1, 1, 0, 1);
        step();
        issue_valid_i = 1'b0;
        step();
        step();

        // LMUL=8 group on vs2 8..15.
        set_issue(1, 3, 0, 8, 16, 0, 1, 0, 1);
        step();
        issue_valid_i = 1'b0;
        repeat (9) step();

        // LMUL=4 with vd group wrapping 30,31,0,1.
        set_issue(1, 2, 10, 24, 30, 1, 1, 1, 1);
        step();
        issue_valid_i = 1'b0;
        repeat (5) step();

        // RAW stall on v4 released by write-back.
        set_issue(1, 0, 0, 0, 4, 0, 0, 0, 1);
        step();
        issue_valid_i = 1'b0;
        repeat (2) step();
        set_issue(1, 0, 4, 12, 13, 1, 0, 0, 0);
        repeat (3) step();
        wb_valid_i   = 1'b1;
        wb_address_i = 5'd4;
        step();
        wb_valid_i = 1'b0;
        step();
        issue_valid_i = 1'b0;
        repeat (2) step();

        // Downstream back-pressure 1,0,0,1 on a two-beat group.
        set_issue(1, 1, 2, 3, 5, 1, 0, 0, 0);
        step();
        issue_valid_i = 1'b0;
        step();
        read_ready_i = 1'b0;
        repeat (2) step();
        read_ready_i = 1'b1;
        repeat (2) step();

        // Set and clear of the same busy bit in one cycle.
        set_issue(1, 0, 6, 6, 9, 0, 0, 0, 1);
        wb_valid_i   = 1'b1;
        wb_address_i = 5'd9;
        step();
        wb_valid_i    = 1'b0;
        issue_valid_i = 1'b0;
        repeat (2) step();

        // Random traffic; write-backs mostly retire currently busy registers.
        for (int it = 0; it < 400; it++) begin
            set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1);
            read_ready_i = ($urandom_range(0, 3) != 0);
            wb_valid_i   = ($urandom_range(0, 1) == 1);
            wb_address_i = AW'($urandom_range(0, 31));
            begin
                int start;
                start = $urandom_range(0, 31);
                for (int k = 0; k < D; k++) begin
                    if (m_busy[(start + k) % D]) begin
                        wb_address_i = AW'((start + k) % D);
                        break;
                    end
                end
            end
            step();
        end
        set_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid_i   = 1'b0;
        read_ready_i = 1'b1;
        repeat (10) step();

        // Reset asserted at beat 2 of a four-beat group.
        set_issue(1, 2, 20, 21, 22, 0, 0, 0, 0);
        step();
        issue_valid_i = 1'b0;
        repeat (2) step();
        #2;
        rstn_i = 1'b0;
        #1;
        m_q.delete();
        m_busy = '0;
        check_outputs();
        check("reset_vs1_addr", 32'(vs1_read_address_o), 32'd0);
        check("reset_vs2_addr", 32'(vs2_read_address_o), 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        set_issue(1, 1, 14, 15, 16, 1, 1, 1, 1);
        step();
        issue_valid_i = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
